// File: rtl/password_checker_if.sv
// Keypad-side bundle for password_checker: key strobe and lockout in, result pulses and status out.
// key_valid is a one-cycle strobe with no ready: a key is consumed or dropped in the cycle it is valid.
interface password_checker_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       gen_stop;
  logic       unlock;
  logic       gen_rst;
  logic       pwd_updated;
  logic [2:0] digit_cnt;
  logic [2:0] fsm_state;

  modport master (
    output key_valid, key_code, gen_stop,
    input  unlock, gen_rst, pwd_updated, digit_cnt, fsm_state
  );

  modport slave (
    input  key_valid, key_code, gen_stop,
    output unlock, gen_rst, pwd_updated, digit_cnt, fsm_state
  );
endinterface

// File: rtl/password_checker.sv
// Keypad password checker FSM with registered one-cycle unlock/gen_rst/pwd_updated pulses.
// Define PWD_CHANGE_EN to enable the UNLOCKED -> NEW_ENTRY password-change path.
module password_checker #(
  parameter int unsigned          PWD_LEN     = 4,
  parameter logic [4*PWD_LEN-1:0] DEFAULT_PWD = 16'h1234
) (
  input logic               clk,
  input logic               rst_n,
  password_checker_if.slave bus
);
  localparam int unsigned BW   = 4 * PWD_LEN;
  localparam logic [2:0]  LEN3 = 3'(PWD_LEN);

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, UNLOCKED, NEW_ENTRY, LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] dig_q, dig_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          match_q, match_d;
  logic          fail_q, fail_d;
  logic          unlock_q, unlock_d;
  logic          gen_rst_q, gen_rst_d;
  logic [BW-1:0] pwd_cur;
  logic [BW-1:0] dig_app;
  logic          key_dig, key_clr, key_ent, cmp_ok;

  assign key_dig = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_clr = bus.key_valid && (bus.key_code == 4'hA);
  assign key_ent = bus.key_valid && (bus.key_code == 4'hB);
  assign dig_app = (dig_q << 4) | BW'(bus.key_code);
  assign cmp_ok  = (cnt_q == LEN3) && !ovf_q && (dig_q == pwd_cur);

`ifdef PWD_CHANGE_EN
  logic          key_chg;
  logic          upd_q, upd_d;
  logic [BW-1:0] pwd_q, pwd_d;
  assign key_chg         = bus.key_valid && (bus.key_code == 4'hC);
  assign pwd_cur         = pwd_q;
  assign bus.pwd_updated = upd_q;
`else
  assign pwd_cur         = DEFAULT_PWD;
  assign bus.pwd_updated = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dig_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      match_q   <= 1'b0;
      fail_q    <= 1'b0;
      unlock_q  <= 1'b0;
      gen_rst_q <= 1'b0;
`ifdef PWD_CHANGE_EN
      upd_q     <= 1'b0;
      pwd_q     <= DEFAULT_PWD;
`endif
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      match_q   <= match_d;
      fail_q    <= fail_d;
      unlock_q  <= unlock_d;
      gen_rst_q <= gen_rst_d;
`ifdef PWD_CHANGE_EN
      upd_q     <= upd_d;
      pwd_q     <= pwd_d;
`endif
    end
  end

  // The CHECK verdict is held one extra cycle in match_q/fail_q so the pulse
  // lands two edges after ENTER and can still be cancelled by gen_stop.
  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    match_d   = 1'b0;
    fail_d    = 1'b0;
    unlock_d  = match_q;
    gen_rst_d = fail_q;
`ifdef PWD_CHANGE_EN
    upd_d     = 1'b0;
    pwd_d     = pwd_q;
`endif
    if (bus.gen_stop) begin
      state_d   = LOCKED;
      dig_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      unlock_d  = 1'b0;
      gen_rst_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          if (key_dig) begin
            state_d = ENTRY;
            if (cnt_q == LEN3) begin
              ovf_d = 1'b1;
            end else begin
              dig_d = dig_app;
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_clr) begin
            state_d = IDLE;
            dig_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else if (key_ent && (state_q == ENTRY)) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          match_d = cmp_ok;
          fail_d  = !cmp_ok;
          dig_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef PWD_CHANGE_EN
          state_d = cmp_ok ? UNLOCKED : IDLE;
`else
          state_d = IDLE;
`endif
        end
`ifdef PWD_CHANGE_EN
        UNLOCKED: begin
          if (key_chg) begin
            state_d = NEW_ENTRY;
          end else if (bus.key_valid && (bus.key_code <= 4'hB)) begin
            state_d = IDLE;
          end
        end
        NEW_ENTRY: begin
          if (key_dig) begin
            if (cnt_q == LEN3) begin
              ovf_d = 1'b1;
            end else begin
              dig_d = dig_app;
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_clr || key_ent) begin
            if (key_ent && (cnt_q == LEN3) && !ovf_q) begin
              pwd_d = dig_q;
              upd_d = 1'b1;
            end
            state_d = IDLE;
            dig_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
`endif
        LOCKED:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.unlock    = unlock_q;
  assign bus.gen_rst   = gen_rst_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.fsm_state = state_q;
endmodule
